// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, funct, ALU and mux-select encodings for the multicycle MIPS controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, RWB, BRANCH, ADDI_EX, ADDI_WB, JUMP, ILLEGAL
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_4 = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps R-type funct to ALU_func and flags unsupported funct codes
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_func,
  output logic       funct_legal
);
  always_comb begin
    alu_func = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      F_ADD: alu_func = ALU_ADD;
      F_SUB: alu_func = ALU_SUB;
      F_AND: alu_func = ALU_AND;
      F_OR: alu_func = ALU_OR;
      F_SLT: alu_func = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control FSM sequencing datapath enables, mux selects and ALU codes
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PC_WE,
  output logic       IR_WE,
  output logic       MDR_WE,
  output logic       ALUOut_WE,
  output logic       RF_WE,
  output logic       MEM_RE,
  output logic       MEM_WE,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [3:0] ALU_func,
  output logic       instr_done,
  output logic       illegal
);
  state_t state_q, state_d;
  logic [3:0] r_func;
  logic funct_legal;
  mc_alu_decode u_alu_decode (
    .funct(funct),
    .alu_func(r_func),
    .funct_legal(funct_legal)
  );
  always_ff @(posedge CLK or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    PC_WE = 1'b0;
    IR_WE = 1'b0;
    MDR_WE = 1'b0;
    ALUOut_WE = 1'b0;
    RF_WE = 1'b0;
    MEM_RE = 1'b0;
    MEM_WE = 1'b0;
    IorD = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    PCSrc = PCSRC_ALU;
    RegDst = 1'b0;
    MemToReg = 1'b0;
    ALU_func = ALU_ADD;
    instr_done = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MEM_RE = 1'b1;
        ALUSrcB = SRCB_4;
        IR_WE = mem_ready;
        PC_WE = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        ALUOut_WE = 1'b1;
        state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                  opcode == OP_RTYPE ? (funct_legal ? EXEC : ILLEGAL) :
                  opcode == OP_BEQ ? BRANCH :
                  opcode == OP_ADDI ? ADDI_EX :
                  opcode == OP_J ? JUMP : ILLEGAL;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOut_WE = 1'b1;
        state_d = opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MEM_RE = 1'b1;
        IorD = 1'b1;
        MDR_WE = mem_ready;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RF_WE = 1'b1;
        MemToReg = 1'b1;
        instr_done = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        MEM_WE = 1'b1;
        IorD = 1'b1;
        instr_done = mem_ready;
        state_d = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOut_WE = 1'b1;
        ALU_func = r_func;
        state_d = RWB;
      end
      RWB: begin
        RF_WE = 1'b1;
        RegDst = 1'b1;
        instr_done = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALU_func = ALU_SUB;
        PCSrc = PCSRC_ALUOUT;
        PC_WE = Zero;
        instr_done = 1'b1;
        state_d = FETCH;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOut_WE = 1'b1;
        state_d = ADDI_WB;
      end
      ADDI_WB: begin
        RF_WE = 1'b1;
        instr_done = 1'b1;
        state_d = FETCH;
      end
      JUMP: begin
        PCSrc = PCSRC_JUMP;
        PC_WE = 1'b1;
        instr_done = 1'b1;
        state_d = FETCH;
      end
      ILLEGAL: illegal = 1'b1;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed-vector check of every control state, wait handling, illegal decode and async reset
module tb_mc_control_fsm;
  localparam logic [20:0] PCW = 21'h1 << 20;
  localparam logic [20:0] IRW = 21'h1 << 19;
  localparam logic [20:0] MDRW = 21'h1 << 18;
  localparam logic [20:0] AOW = 21'h1 << 17;
  localparam logic [20:0] RFW = 21'h1 << 16;
  localparam logic [20:0] MRE = 21'h1 << 15;
  localparam logic [20:0] MWE = 21'h1 << 14;
  localparam logic [20:0] IORD = 21'h1 << 13;
  localparam logic [20:0] SA = 21'h1 << 12;
  localparam logic [20:0] SB4 = 21'h1 << 10;
  localparam logic [20:0] SBIMM = 21'h2 << 10;
  localparam logic [20:0] SBSH = 21'h3 << 10;
  localparam logic [20:0] PCAO = 21'h1 << 8;
  localparam logic [20:0] PCJ = 21'h2 << 8;
  localparam logic [20:0] RD = 21'h1 << 7;
  localparam logic [20:0] M2R = 21'h1 << 6;
  localparam logic [20:0] SUBF = 21'h1 << 2;
  localparam logic [20:0] ANDF = 21'h2 << 2;
  localparam logic [20:0] ORF = 21'h3 << 2;
  localparam logic [20:0] SLTF = 21'h4 << 2;
  localparam logic [20:0] DONE = 21'h1 << 1;
  localparam logic [20:0] ILL = 21'h1;
  localparam logic [20:0] E_FETCH = PCW | IRW | MRE | SB4;
  localparam logic [20:0] E_FWAIT = MRE | SB4;
  localparam logic [20:0] E_DEC = SBSH | AOW;
  localparam logic [20:0] E_MADR = SA | SBIMM | AOW;
  logic CLK = 1'b0, reset = 1'b1, Zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'b0, funct = 6'b100000;
  logic PC_WE, IR_WE, MDR_WE, ALUOut_WE, RF_WE, MEM_RE, MEM_WE, IorD, ALUSrcA;
  logic RegDst, MemToReg, instr_done, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALU_func;
  logic [20:0] obs;
  int n_tests = 0, n_fail = 0;
  mc_control_fsm dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .PC_WE(PC_WE), .IR_WE(IR_WE), .MDR_WE(MDR_WE),
    .ALUOut_WE(ALUOut_WE), .RF_WE(RF_WE), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .RegDst(RegDst), .MemToReg(MemToReg), .ALU_func(ALU_func),
    .instr_done(instr_done), .illegal(illegal)
  );
  always #5 CLK = ~CLK;
  assign obs = {PC_WE, IR_WE, MDR_WE, ALUOut_WE, RF_WE, MEM_RE, MEM_WE, IorD, ALUSrcA,
                ALUSrcB, PCSrc, RegDst, MemToReg, ALU_func, instr_done, illegal};
  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic mr, input logic z, input logic [20:0] exp, input string tag);
    @(posedge CLK);
    #2;
    mem_ready = mr;
    Zero = z;
    #1;
    check(tag, obs, exp);
  endtask
  task automatic rst_pulse();
    #1 reset = 1'b1;
    #1 check("reset_async", obs, 21'h0);
    @(posedge CLK);
    #3 check("reset_hold", obs, 21'h0);
    reset = 1'b0;
  endtask
  initial begin
    logic [5:0] fn [4];
    logic [20:0] fe [4];
    fn = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    fe = '{SUBF, ANDF, ORF, SLTF};
    #1 check("reset_idle", obs, 21'h0);
    @(posedge CLK);
    #3 check("reset_idle_edge", obs, 21'h0);
    reset = 1'b0;
    cyc(1, 0, E_FETCH, "add_fetch");
    cyc(1, 0, E_DEC, "add_decode");
    cyc(1, 0, SA | AOW, "add_exec");
    cyc(1, 0, RFW | RD | DONE, "add_rwb");
    for (int i = 0; i < 4; i++) begin
      funct = fn[i];
      cyc(1, 0, E_FETCH, "r_fetch");
      cyc(1, 0, E_DEC, "r_decode");
      cyc(1, 0, SA | AOW | fe[i], "r_exec_func");
      cyc(1, 0, RFW | RD | DONE, "r_rwb");
    end
    opcode = 6'b100011;
    cyc(1, 0, E_FETCH, "lw_fetch");
    cyc(0, 0, E_DEC, "lw_decode_ignores_ready");
    cyc(0, 0, E_MADR, "lw_memadr");
    cyc(0, 0, MRE | IORD, "lw_memrd_wait1");
    cyc(0, 0, MRE | IORD, "lw_memrd_wait2");
    cyc(0, 0, MRE | IORD, "lw_memrd_wait3");
    cyc(1, 0, MRE | IORD | MDRW, "lw_memrd_ready");
    cyc(1, 0, RFW | M2R | DONE, "lw_memwb");
    opcode = 6'b101011;
    cyc(0, 0, E_FWAIT, "sw_fetch_wait");
    cyc(1, 0, E_FETCH, "sw_fetch_ready");
    cyc(1, 0, E_DEC, "sw_decode");
    cyc(0, 0, E_MADR, "sw_memadr");
    cyc(0, 0, MWE | IORD, "sw_memwr_wait");
    cyc(1, 0, MWE | IORD | DONE, "sw_memwr_ready");
    opcode = 6'b001000;
    cyc(1, 0, E_FETCH, "addi_fetch");
    cyc(1, 0, E_DEC, "addi_decode");
    cyc(1, 0, E_MADR, "addi_ex");
    cyc(1, 0, RFW | DONE, "addi_wb");
    opcode = 6'b000100;
    cyc(1, 1, E_FETCH, "beq_fetch_ignores_zero");
    cyc(1, 1, E_DEC, "beq_decode");
    cyc(1, 1, SA | SUBF | PCAO | PCW | DONE, "beq_taken");
    cyc(1, 0, E_FETCH, "beq2_fetch");
    cyc(1, 0, E_DEC, "beq2_decode");
    cyc(1, 0, SA | SUBF | PCAO | DONE, "beq_not_taken");
    opcode = 6'b000010;
    cyc(1, 0, E_FETCH, "j_fetch");
    cyc(1, 0, E_DEC, "j_decode");
    cyc(1, 0, PCJ | PCW | DONE, "j_jump");
    opcode = 6'b101011;
    cyc(1, 0, E_FETCH, "swr_fetch");
    cyc(1, 0, E_DEC, "swr_decode");
    cyc(0, 0, E_MADR, "swr_memadr");
    cyc(0, 0, MWE | IORD, "swr_memwr");
    rst_pulse();
    opcode = 6'b111111;
    cyc(1, 0, E_FETCH, "badop_fetch");
    cyc(1, 0, E_DEC, "badop_decode");
    cyc(1, 0, ILL, "badop_illegal");
    cyc(1, 1, ILL, "badop_sticky1");
    cyc(1, 0, ILL, "badop_sticky2");
    rst_pulse();
    opcode = 6'b000000;
    funct = 6'b000111;
    cyc(1, 0, E_FETCH, "badfn_fetch");
    cyc(1, 0, E_DEC, "badfn_decode");
    cyc(1, 0, ILL, "badfn_illegal");
    cyc(1, 0, ILL, "badfn_sticky");
    rst_pulse();
    funct = 6'b100000;
    cyc(1, 0, E_FETCH, "post_reset_fetch");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
